// File: rtl/imem_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit IMEM words,
// pads the rest of IMEM with NOPs and holds the core in reset until the image is in place.
module imem_loader #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RST_CYCLES = 4,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {S_LOAD, S_FILL, S_RELEASE, S_RUN} state_e;

    localparam int unsigned      AW1       = ADDR_W + 1;
    localparam int unsigned      RC_W      = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [AW1-1:0]   FULL_CNT  = AW1'(IMEM_WORDS);
    localparam logic [AW1-1:0]   LAST_ADDR = AW1'(IMEM_WORDS - 1);
    localparam logic [RC_W-1:0]  RC_END    = RC_W'(RST_CYCLES);

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       acc_q, acc_d;
    logic [AW1-1:0]    word_addr_q, word_addr_d;
    logic [AW1-1:0]    words_loaded_q, words_loaded_d;
    logic [RC_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic              overflow;
    logic              emit;
    logic [31:0]       lane_data;
    logic [AW1-1:0]    addr_after;

    assign accept     = in_valid && in_ready_q;
    assign overflow   = (words_loaded_q == FULL_CNT);
    assign emit       = accept && !overflow && (in_last || (byte_cnt_q == 2'd3));
    assign lane_data  = {24'd0, in_data} << {byte_cnt_q, 3'b000};
    assign addr_after = emit ? (word_addr_q + AW1'(1)) : word_addr_q;

    // NOTE: every register is updated with <= so all flops see pre-edge values of each other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_LOAD;
            byte_cnt_q     <= '0;
            acc_q          <= '0;
            word_addr_q    <= '0;
            words_loaded_q <= '0;
            rel_cnt_q      <= '0;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_reset_q   <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            acc_q          <= acc_d;
            word_addr_q    <= word_addr_d;
            words_loaded_q <= words_loaded_d;
            rel_cnt_q      <= rel_cnt_d;
            in_ready_q     <= in_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_reset_q   <= core_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:    if (accept && in_last) state_d = (addr_after < FULL_CNT) ? S_FILL : S_RELEASE;
            S_FILL:    if (word_addr_q == LAST_ADDR) state_d = S_RELEASE;
            S_RELEASE: if (rel_cnt_q == RC_END) state_d = S_RUN;
            S_RUN:     if (load_req) state_d = S_LOAD;
            default:   state_d = S_LOAD;
        endcase
    end

    // NOTE: each always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        byte_cnt_d     = byte_cnt_q;
        acc_d          = acc_q;
        word_addr_d    = word_addr_q;
        words_loaded_d = words_loaded_q;
        rel_cnt_d      = '0;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        error_d        = error_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (overflow) begin
                        error_d = 1'b1;
                    end else if (emit) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = word_addr_q[ADDR_W-1:0];
                        imem_wdata_d   = acc_q | lane_data;
                        word_addr_d    = addr_after;
                        words_loaded_d = words_loaded_q + AW1'(1);
                        acc_d          = '0;
                        byte_cnt_d     = '0;
                    end else begin
                        acc_d      = acc_q | lane_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                    // A last byte that was dropped still leaves the packer clean for a reload.
                    if (in_last) begin
                        acc_d      = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
            S_FILL: begin
                imem_we_d    = 1'b1;
                imem_addr_d  = word_addr_q[ADDR_W-1:0];
                imem_wdata_d = NOP_WORD;
                word_addr_d  = word_addr_q + AW1'(1);
            end
            S_RELEASE: rel_cnt_d = rel_cnt_q + RC_W'(1);
            S_RUN: begin
                if (load_req) begin
                    byte_cnt_d     = '0;
                    acc_d          = '0;
                    word_addr_d    = '0;
                    words_loaded_d = '0;
                    error_d        = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign in_ready_d   = (state_d == S_LOAD);
    assign core_reset_d = (state_d != S_RUN);
    assign done_d       = (state_d == S_RUN);

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: image packing, NOP fill, core release,
// overflow, asynchronous reset mid-load and reload from RUN.
module tb_imem_loader;
    localparam int          IMEM_WORDS = 256;
    localparam int          ADDR_W     = 8;
    localparam int          RST_CYCLES = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              load_req = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int errors = 0;
    int checks = 0;

    logic [7:0]  basic_img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int          gap_tab   [8] = '{0, 2, 1, 3, 0, 1, 2, 1};
    logic [31:0] exp_mem   [IMEM_WORDS];

    always #5 clk = ~clk;

    imem_loader #(
        .IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    // Write log and core_reset fall time, sampled on the falling edge.
    logic [ADDR_W-1:0] wr_addr [$];
    logic [31:0]       wr_data [$];
    int                wr_cyc  [$];
    int                ncyc = 0;
    int                fall_cyc = -1;
    logic              core_reset_prev = 1'b1;
    bit                bad_we = 1'b0;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(ncyc);
            if (core_reset !== 1'b1) bad_we <= 1'b1;
        end
        if (core_reset_prev === 1'b1 && core_reset === 1'b0) fall_cyc <= ncyc;
        core_reset_prev <= core_reset;
    end

    function automatic int log_mismatches(input int base);
        int m = 0;
        for (int i = 0; i < IMEM_WORDS; i++)
            if (base + i >= wr_addr.size() || wr_addr[base+i] !== ADDR_W'(i) ||
                wr_data[base+i] !== exp_mem[i]) m++;
        return m;
    endfunction

    function automatic int fill_gaps(input int base, input int from);
        int g = 0;
        for (int i = from; i < IMEM_WORDS; i++)
            if (base + i >= wr_cyc.size() || wr_cyc[base+i] != wr_cyc[base+i-1] + 1) g++;
        return g;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap,
                             output logic we_after);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        we_after = imem_we;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", tag, done, n);
        end
        @(negedge clk);
    endtask

    task automatic pulse_load_req;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Drives the two-word basic image (optionally with in_valid gaps) and checks the whole load.
    task automatic run_basic_image(input bit use_gaps, input string tag);
        int   base = wr_addr.size();
        int   we_bad = 0;
        int   gap_sum = 0;
        int   m;
        logic we;
        for (int i = 0; i < 8; i++) begin
            send_byte(basic_img[i], (i == 7), use_gaps ? gap_tab[i] : 0, we);
            if (we !== ((i % 4) == 3)) we_bad++;
            if (use_gaps && i >= 4) gap_sum += gap_tab[i];
        end
        checks++;
        if (we_bad !== 0) begin errors++;
            $display("FAIL %s_write_timing: %0d bytes with wrong strobe, required 0", tag, we_bad); end
        wait_done(tag);
        foreach (exp_mem[i]) exp_mem[i] = NOP;
        exp_mem[0] = 32'h0000_0013;
        exp_mem[1] = 32'h0010_0093;
        checks++;
        if (wr_addr.size() - base !== IMEM_WORDS) begin errors++;
            $display("FAIL %s_write_count: got %0d, required %0d", tag, wr_addr.size() - base, IMEM_WORDS); end
        m = log_mismatches(base);
        checks++;
        if (m !== 0) begin errors++;
            $display("FAIL %s_write_data: %0d wrong words, required 0 (addr1 data=%h)", tag, m, wr_data[base+1]); end
        checks++;
        if (wr_cyc[base+1] - wr_cyc[base] !== 4 + gap_sum) begin errors++;
            $display("FAIL %s_word_spacing: got %0d cycles, required %0d", tag,
                     wr_cyc[base+1] - wr_cyc[base], 4 + gap_sum); end
        checks++;
        if (fill_gaps(base, 2) !== 0) begin errors++;
            $display("FAIL %s_fill_rate: %0d gaps, required 0", tag, fill_gaps(base, 2)); end
        checks++;
        if (fall_cyc - wr_cyc[wr_cyc.size()-1] !== RST_CYCLES + 1) begin errors++;
            $display("FAIL %s_release_delay: got %0d, required %0d", tag,
                     fall_cyc - wr_cyc[wr_cyc.size()-1], RST_CYCLES + 1); end
        checks++;
        if (words_loaded !== 9'd2) begin errors++;
            $display("FAIL %s_words_loaded: got %0d, required 2", tag, words_loaded); end
        checks++;
        if ({core_reset, done, error, in_ready} !== 4'b0100) begin errors++;
            $display("FAIL %s_run_flags: core_reset/done/error/in_ready got %b, required 0100", tag,
                     {core_reset, done, error, in_ready}); end
    endtask

    task automatic test_reset;
        logic [53:0] got;
        logic [53:0] want = {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        got = {in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error, words_loaded};
        checks++;
        if (got !== want) begin errors++;
            $display("FAIL reset_values: got %h, required %h", got, want); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready_early: got %b, required 0", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready_rise: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic;
        run_basic_image(1'b0, "basic");
        checks++;
        if (bad_we !== 1'b0) begin errors++;
            $display("FAIL basic_core_reset_during_write: got %b, required 0", bad_we); end
    endtask

    task automatic test_partial;
        int   base;
        int   m;
        int   we_bad = 0;
        logic we;
        logic [7:0] img [5] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hAB};
        pulse_load_req();
        base = wr_addr.size();
        for (int i = 0; i < 5; i++) begin
            send_byte(img[i], (i == 4), 0, we);
            if (we !== (i >= 3)) we_bad++;
        end
        checks++;
        if (we_bad !== 0) begin errors++;
            $display("FAIL partial_write_timing: %0d bytes with wrong strobe, required 0", we_bad); end
        pulse_load_req();
        checks++;
        if ({in_ready, imem_we, imem_addr} !== {1'b0, 1'b1, 8'd2}) begin errors++;
            $display("FAIL partial_load_req_in_fill: ready/we/addr got %b/%b/%0d, required 0/1/2",
                     in_ready, imem_we, imem_addr); end
        wait_done("partial");
        foreach (exp_mem[i]) exp_mem[i] = NOP;
        exp_mem[0] = 32'h0000_0013;
        exp_mem[1] = 32'h0000_00AB;
        m = log_mismatches(base);
        checks++;
        if (wr_addr.size() - base !== IMEM_WORDS || m !== 0) begin errors++;
            $display("FAIL partial_writes: count %0d, %0d wrong words, required %0d and 0",
                     wr_addr.size() - base, m, IMEM_WORDS); end
        checks++;
        if (wr_cyc[base+2] - wr_cyc[base+1] !== 1) begin errors++;
            $display("FAIL partial_fill_start: gap %0d, required 1", wr_cyc[base+2] - wr_cyc[base+1]); end
        checks++;
        if (words_loaded !== 9'd2 || done !== 1'b1) begin errors++;
            $display("FAIL partial_status: words_loaded=%0d done=%b, required 2 and 1", words_loaded, done); end
    endtask

    task automatic test_gaps;
        pulse_load_req();
        run_basic_image(1'b1, "gaps");
    endtask

    task automatic test_reset_mid_load;
        logic [53:0] got;
        logic [53:0] want = {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 9'd0};
        logic we;
        pulse_load_req();
        for (int i = 0; i < 6; i++) send_byte(basic_img[i], 1'b0, 0, we);
        reset = 1'b0;
        #1;
        got = {in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error, words_loaded};
        checks++;
        if (got !== want) begin errors++;
            $display("FAIL midload_reset_values: got %h, required %h", got, want); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_basic_image(1'b0, "replay");
    endtask

    task automatic test_long_image(input int n_bytes, input string tag);
        int   base;
        int   m;
        int   we_bad = 0;
        logic we;
        pulse_load_req();
        base = wr_addr.size();
        for (int i = 0; i < n_bytes; i++) begin
            send_byte(8'(i), (i == n_bytes - 1), 0, we);
            if (we !== (i < 4 * IMEM_WORDS && (i % 4) == 3)) we_bad++;
        end
        checks++;
        if (we_bad !== 0) begin errors++;
            $display("FAIL %s_write_timing: %0d bytes with wrong strobe, required 0", tag, we_bad); end
        wait_done(tag);
        foreach (exp_mem[w]) exp_mem[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        m = log_mismatches(base);
        checks++;
        if (wr_addr.size() - base !== IMEM_WORDS || m !== 0) begin errors++;
            $display("FAIL %s_writes: count %0d, %0d wrong words, required %0d and 0",
                     tag, wr_addr.size() - base, m, IMEM_WORDS); end
        checks++;
        if (error !== (n_bytes > 4 * IMEM_WORDS)) begin errors++;
            $display("FAIL %s_error: got %b, required %b", tag, error, (n_bytes > 4 * IMEM_WORDS)); end
        checks++;
        if (words_loaded !== 9'd256 || core_reset !== 1'b0) begin errors++;
            $display("FAIL %s_status: words_loaded=%0d core_reset=%b, required 256 and 0",
                     tag, words_loaded, core_reset); end
        checks++;
        if (fall_cyc - wr_cyc[wr_cyc.size()-1] !== RST_CYCLES + 1 + (n_bytes - 4 * IMEM_WORDS)) begin
            errors++;
            $display("FAIL %s_release_delay: got %0d, required %0d", tag, fall_cyc - wr_cyc[wr_cyc.size()-1],
                     RST_CYCLES + 1 + (n_bytes - 4 * IMEM_WORDS)); end
    endtask

    task automatic test_reload;
        int   base;
        int   m;
        int   we_bad = 0;
        logic we;
        logic [7:0] img [4] = '{8'h6F, 8'h00, 8'h00, 8'h00};
        base = wr_addr.size();
        pulse_load_req();
        checks++;
        if ({core_reset, done, error, in_ready} !== 4'b1001) begin errors++;
            $display("FAIL reload_entry: core_reset/done/error/in_ready got %b, required 1001",
                     {core_reset, done, error, in_ready}); end
        for (int i = 0; i < 4; i++) begin
            send_byte(img[i], (i == 3), 0, we);
            if (we !== (i == 3)) we_bad++;
        end
        checks++;
        if (we_bad !== 0) begin errors++;
            $display("FAIL reload_write_timing: %0d bytes with wrong strobe, required 0", we_bad); end
        wait_done("reload");
        foreach (exp_mem[i]) exp_mem[i] = NOP;
        exp_mem[0] = 32'h0000_006F;
        m = log_mismatches(base);
        checks++;
        if (wr_addr.size() - base !== IMEM_WORDS || m !== 0) begin errors++;
            $display("FAIL reload_writes: count %0d, %0d wrong words, required %0d and 0",
                     wr_addr.size() - base, m, IMEM_WORDS); end
        checks++;
        if (words_loaded !== 9'd1 || {core_reset, done, error} !== 3'b010) begin errors++;
            $display("FAIL reload_status: words_loaded=%0d core_reset/done/error=%b, required 1 and 010",
                     words_loaded, {core_reset, done, error}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_gaps();
        test_reset_mid_load();
        test_long_image(1024, "exact_fit");
        test_long_image(1028, "overflow");
        test_reload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
